// File: rtl/scan_pkg.sv
// Shared types for the display digit-select scanner: digit count, digit index and FSM states.
package scan_pkg;

    localparam int N_DIGITS = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK
    } scan_state_t;

endpackage

// File: rtl/scan_next_sel.sv
// Circular priority search: the first enabled digit after cur (order 0->1->2->3->0).
// wrap flags that the search came back to an index <= cur, i.e. a frame boundary.
module scan_next_sel
    import scan_pkg::*;
(
    input  sel_t                cur,
    input  logic [N_DIGITS-1:0] mask,
    output sel_t                nxt,
    output logic                wrap
);

    sel_t                cand [N_DIGITS];
    logic [N_DIGITS-1:0] hit;

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_cand
        assign cand[gi] = cur + sel_t'(gi + 1);
        assign hit[gi]  = mask[cand[gi]];
    end

    // Nearest candidate wins; with an empty mask the index holds.
    always_comb begin
        nxt = cur;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                nxt = cand[k];
            end
        end
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Multiplexed display scanner driving a 2:4 decoder (sel -> A, en -> E) with blanking gaps.
// Define SCAN_SKIP_EN to honour digit_mask; otherwise all four digits are always scanned.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [N_DIGITS-1:0] digit_mask,
    output logic [1:0]          sel,
    output logic                en,
    output logic                frame_done
);

    localparam int PW         = $clog2(DIV + 1);
    localparam int BW         = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam int BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLANK_LAST);

    scan_state_t   state_reg, state_next;
    sel_t          sel_reg, sel_next;
    logic          en_reg, en_next;
    logic          frame_done_reg, frame_done_next;
    logic [PW-1:0] pre_reg, pre_next;
    logic [BW-1:0] blank_reg, blank_next;

    logic [N_DIGITS-1:0] eff_mask;
    logic                mask_zero;
    sel_t                search_from;
    sel_t                next_sel;
    logic                next_wrap;

`ifdef SCAN_SKIP_EN
    assign eff_mask = digit_mask;
`else
    logic unused_mask;
    assign eff_mask    = '1;
    assign unused_mask = ^digit_mask;
`endif

    assign mask_zero = (eff_mask == '0);

    // Searching from digit 3 on IDLE exit yields the lowest enabled digit.
    assign search_from = (state_reg == IDLE) ? sel_t'(N_DIGITS - 1) : sel_reg;

    scan_next_sel u_next_sel (
        .cur  (search_from),
        .mask (eff_mask),
        .nxt  (next_sel),
        .wrap (next_wrap)
    );

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        pre_next        = pre_reg;
        blank_next      = blank_reg;
        frame_done_next = 1'b0;

        if (!run || (state_reg != IDLE && mask_zero)) begin
            state_next = IDLE;
            sel_next   = '0;
            pre_next   = '0;
            blank_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!mask_zero) begin
                        state_next = ACTIVE;
                        sel_next   = next_sel;
                        pre_next   = '0;
                    end
                end
                ACTIVE: begin
                    if (pre_reg == PRE_LAST) begin
                        sel_next        = next_sel;
                        frame_done_next = next_wrap;
                        pre_next        = '0;
                        blank_next      = '0;
                        state_next      = (BLANK_CYC > 0) ? BLANK : ACTIVE;
                    end else begin
                        pre_next = pre_reg + PW'(1);
                    end
                end
                BLANK: begin
                    if (blank_reg == BLK_LAST) begin
                        state_next = ACTIVE;
                        blank_next = '0;
                    end else begin
                        blank_next = blank_reg + BW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    sel_next   = '0;
                    pre_next   = '0;
                    blank_next = '0;
                end
            endcase
        end

        en_next = (state_next == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            en_reg         <= 1'b0;
            frame_done_reg <= 1'b0;
            pre_reg        <= '0;
            blank_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            en_reg         <= en_next;
            frame_done_reg <= frame_done_next;
            pre_reg        <= pre_next;
            blank_reg      <= blank_next;
        end
    end

    assign sel        = sel_reg;
    assign en         = en_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench: per-cycle vector table on a DIV=4/BLANK_CYC=1 scanner plus a
// hand-written sequence on a DIV=1/BLANK_CYC=0 instance.
module tb_scan_sel_gen;

    logic       clk = 1'b0;
    logic       rst_n, run;
    logic [3:0] digit_mask;
    logic [1:0] sel;
    logic       en, frame_done;

    logic       rst_n2, run2;
    logic [3:0] digit_mask2;
    logic [1:0] sel2;
    logic       en2, frame_done2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scan_sel_gen #(.DIV(4), .BLANK_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .digit_mask (digit_mask),
        .sel        (sel),
        .en         (en),
        .frame_done (frame_done)
    );

    scan_sel_gen #(.DIV(1), .BLANK_CYC(0)) dut_fast (
        .clk        (clk),
        .rst_n      (rst_n2),
        .run        (run2),
        .digit_mask (digit_mask2),
        .sel        (sel2),
        .en         (en2),
        .frame_done (frame_done2)
    );

    typedef struct {
        logic       rst_n;
        logic       run;
        logic [3:0] mask;
        logic [1:0] sel;
        logic       en;
        logic       fd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int n, input logic r, input logic ru, input logic [3:0] m,
                                input logic [1:0] s, input logic e, input logic f);
        vec_t v;
        v.rst_n = r; v.run = ru; v.mask = m; v.sel = s; v.en = e; v.fd = f;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] fast_sel [6];
        logic       fast_fd  [6];

        rst_n = 1'b0; run = 1'b0; digit_mask = 4'hF;
        rst_n2 = 1'b0; run2 = 1'b0; digit_mask2 = 4'hF;

        // Reset, then a full frame from reset: en 1-4 sel0, gap, 6-9 sel1, ...
        add(1, 0, 0, 4'hF, 0, 0, 0);
        add(1, 0, 1, 4'hF, 0, 0, 0);
        add(4, 1, 1, 4'hF, 0, 1, 0);
        add(1, 1, 1, 4'hF, 1, 0, 0);
        add(4, 1, 1, 4'hF, 1, 1, 0);
        add(1, 1, 1, 4'hF, 2, 0, 0);
        add(4, 1, 1, 4'hF, 2, 1, 0);
        add(1, 1, 1, 4'hF, 3, 0, 0);
        add(4, 1, 1, 4'hF, 3, 1, 0);
        add(1, 1, 1, 4'hF, 0, 0, 1);
        add(4, 1, 1, 4'hF, 0, 1, 0);
        add(1, 1, 1, 4'hF, 1, 0, 0);
        // One reset cycle mid-BLANK, then restart from digit 0
        add(1, 0, 1, 4'hF, 0, 0, 0);
        add(4, 1, 1, 4'hF, 0, 1, 0);
        add(1, 1, 1, 4'hF, 1, 0, 0);
        add(4, 1, 1, 4'hF, 1, 1, 0);
        add(1, 1, 1, 4'hF, 2, 0, 0);
        add(2, 1, 1, 4'hF, 2, 1, 0);
        // run dropped on 2nd active cycle of digit 2, then a full restart at digit 0
        add(2, 1, 0, 4'hF, 0, 0, 0);
        add(4, 1, 1, 4'hF, 0, 1, 0);
        add(1, 1, 1, 4'hF, 1, 0, 0);
`ifdef SCAN_SKIP_EN
        add(1, 1, 0, 4'hA, 0, 0, 0);
        add(4, 1, 1, 4'hA, 1, 1, 0);
        add(1, 1, 1, 4'hA, 3, 0, 0);
        add(4, 1, 1, 4'hA, 3, 1, 0);
        add(1, 1, 1, 4'hA, 1, 0, 1);
        add(4, 1, 1, 4'hA, 1, 1, 0);
        add(1, 1, 1, 4'hA, 3, 0, 0);
        add(4, 1, 1, 4'hA, 3, 1, 0);
        add(1, 1, 1, 4'hA, 1, 0, 1);
        // mask 0001 takes effect only at the next advance; then mask 0 mid-ACTIVE
        add(4, 1, 1, 4'h1, 1, 1, 0);
        add(1, 1, 1, 4'h1, 0, 0, 1);
        add(2, 1, 1, 4'h1, 0, 1, 0);
        add(2, 1, 1, 4'h0, 0, 0, 0);
        add(1, 1, 1, 4'h1, 0, 1, 0);
`else
        // Mask is ignored: zero mask keeps scanning, 1010 still visits digit 2
        add(4, 1, 1, 4'h0, 1, 1, 0);
        add(1, 1, 1, 4'hA, 2, 0, 0);
        add(4, 1, 1, 4'hA, 2, 1, 0);
        add(1, 1, 1, 4'hA, 3, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; run = vecs[i].run; digit_mask = vecs[i].mask;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.sel", i), int'(sel), int'(vecs[i].sel));
            check($sformatf("v%0d.en", i), int'(en), int'(vecs[i].en));
            check($sformatf("v%0d.frame_done", i), int'(frame_done), int'(vecs[i].fd));
            $display("vec %0d: rst_n=%0b run=%0b mask=%b -> sel=%0d en=%0b fd=%0b",
                     i, vecs[i].rst_n, vecs[i].run, vecs[i].mask, sel, en, frame_done);
        end

        // DIV=1, BLANK_CYC=0: en continuously high, sel steps every cycle
        @(negedge clk);
        run = 1'b0; rst_n2 = 1'b0; run2 = 1'b1;
        @(posedge clk);
        #1;
        check("fast.reset.sel", int'(sel2), 0);
        check("fast.reset.en", int'(en2), 0);
        check("fast.reset.fd", int'(frame_done2), 0);
        fast_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        fast_fd  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        rst_n2 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("fast%0d.sel", c), int'(sel2), int'(fast_sel[c]));
            check($sformatf("fast%0d.en", c), int'(en2), 1);
            check($sformatf("fast%0d.fd", c), int'(frame_done2), int'(fast_fd[c]));
            $display("fast cycle %0d: sel=%0d en=%0b fd=%0b", c, sel2, en2, frame_done2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
